alu_arbiter: RTL and testbench

//  Shares one combinational ALU (add/sub/and/asr, 2-bit funct) between two requesters.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/rr_arbiter2.sv | 20 ++
 rtl/alu_arbiter.sv | 125 ++++++++++++
 tb/tb_alu_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
//   Shared types for the ALU arbiter slice.
//   alu_funct_t : 2-bit ALU operation code (add, sub, and, arithmetic shift right)
//   arb_state_t : arbiter FSM states (IDLE -> EXEC -> RESP)
// ----------------------------------------------------------------------------
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_ASR = 2'b11
   } alu_funct_t;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin grant logic (purely combinational).
//   req   in  2  request lines
//   ptr   in  1  requester favoured when both request
//   grant out 2  one-hot grant, zero when nothing requests
// ----------------------------------------------------------------------------
module rr_arbiter2
   import alu_pkg::*;
(
   input  logic [1:0] req,
   input  logic       ptr,
   output logic [1:0] grant
);

   // A lone requester always wins; on contention the pointer decides.
   assign grant[0] = req[0] & (~req[1] | ~ptr);
   assign grant[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requesters. A request is
//   granted round-robin, its operands are registered onto the ALU ports, the
//   ALU result is registered one cycle later and presented on a single
//   response channel tagged with the requester id. One operation in flight.
//
//   clk, reset               clock, synchronous active-high reset
//   req_valid/req_ready [1:0] per-requester handshake
//   req0_a/b/funct           requester 0 operands and op
//   req1_a/b/funct           requester 1 operands and op
//   alu_a/b/funct            registered drive of the external ALU
//   alu_out/zero/carry       external ALU result and flags
//   rsp_valid/rsp_ready      response handshake
//   rsp_id/data/zero/carry   registered response payload
// ----------------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter bit RR_INIT = 1'b0
)(
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic [1:0]       req0_funct,
   input  logic [1:0]       req1_funct,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_funct,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_zero,
   output logic             rsp_carry
);

   arb_state_t       state_q;
   logic             rr_ptr_q, rr_ptr_d;
   logic             id_q;
   logic [WIDTH-1:0] alu_a_q, alu_b_q;
   alu_funct_t       alu_funct_q;
   logic             rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_carry_q;
   logic [WIDTH-1:0] rsp_data_q;
   logic [1:0]       grant;
   logic             accept;

   rr_arbiter2 u_rr (
      .req   (req_valid),
      .ptr   (rr_ptr_q),
      .grant (grant)
   );

   // Grants are only offered while idle; reset masks them so nothing is
   // advertised as accepted during a reset cycle.
   assign req_ready = (state_q == IDLE && !reset) ? grant : 2'b00;
   assign accept    = (state_q == IDLE) && (grant != 2'b00);

   // Pointer moves only on an actual accept, away from the winner.
   assign rr_ptr_d  = accept ? ~grant[1] : rr_ptr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= RR_INIT;
         id_q        <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_funct_q <= ALU_ADD;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_data_q  <= '0;
         rsp_zero_q  <= 1'b0;
         rsp_carry_q <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  alu_a_q     <= grant[1] ? req1_a : req0_a;
                  alu_b_q     <= grant[1] ? req1_b : req0_b;
                  alu_funct_q <= alu_funct_t'(grant[1] ? req1_funct : req0_funct);
                  id_q        <= grant[1];
                  state_q     <= EXEC;
               end
            end
            EXEC: begin
               // ALU inputs have been stable for a full cycle; capture result.
               rsp_data_q  <= alu_out;
               rsp_zero_q  <= alu_zero;
               rsp_carry_q <= alu_carry;
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign alu_funct = alu_funct_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;
   assign rsp_carry = rsp_carry_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid, req_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0]  req0_funct, req1_funct;
   logic [31:0] alu_a, alu_b, alu_out;
   logic [1:0]  alu_funct;
   logic        alu_zero, alu_carry;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_carry;
   logic [31:0] rsp_data;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(32), .RR_INIT(1'b0)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
      .req0_funct(req0_funct), .req1_funct(req1_funct),
      .alu_a(alu_a), .alu_b(alu_b), .alu_funct(alu_funct),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry)
   );

   // Stand-in for the external combinational ALU.
   logic [32:0] alu_wide;
   always_comb begin
      alu_wide = 33'd0;
      case (alu_funct)
         2'b00: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
         2'b01: alu_wide = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
         2'b10: alu_wide = {1'b0, alu_a & alu_b};
         default: alu_wide = {1'b0, 32'($signed(alu_a) >>> alu_b[4:0])};
      endcase
   end
   assign alu_out   = alu_wide[31:0];
   assign alu_carry = alu_wide[32];
   assign alu_zero  = (alu_wide[31:0] == 32'd0);

   // Reference result: plain arithmetic on the operation definition.
   function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] f,
                                  output logic [31:0] d, output logic z, output logic c);
      logic [63:0] s;
      s = 64'd0;
      case (f)
         2'b00: begin s = {32'd0, a} + {32'd0, b}; d = s[31:0]; c = (s > 64'hFFFF_FFFF); end
         2'b01: begin d = a - b; c = (a >= b); end
         2'b10: begin d = a & b; c = 1'b0; end
         default: begin d = 32'($signed(a) >>> b[4:0]); c = 1'b0; end
      endcase
      z = (d == 32'd0);
   endfunction

   task automatic drive(input logic [1:0] v,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] f0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] f1);
      req_valid = v;
      req0_a = a0; req0_b = b0; req0_funct = f0;
      req1_a = a1; req1_b = b1; req1_funct = f1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rsp_ready = 1'b1;
      drive(2'b11, 32'h1234, 32'h55, 2'b01, 32'hABCD, 32'h3, 2'b11);
      repeat (2) @(posedge clk);
      #1;
      tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      tests++; if ({alu_a, alu_b, alu_funct} !== 66'd0) begin fails++; $display("FAIL reset_alu got %h/%h/%b want 0", alu_a, alu_b, alu_funct); end
      tests++; if (rsp_data !== 32'd0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", rsp_data); end
      reset = 1'b0;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_single();
      apply_reset();
      rsp_ready = 1'b1;
      drive(2'b01, 32'd5, 32'd7, 2'b00, 32'd0, 32'd0, 2'b00);
      #1;
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready got %b want 01", req_ready); end
      @(posedge clk); #1;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      tests++; if ({alu_a, alu_b, alu_funct} !== {32'd5, 32'd7, 2'b00}) begin fails++; $display("FAIL single_alu got %h/%h/%b want 5/7/00", alu_a, alu_b, alu_funct); end
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid got %b want 0", rsp_valid); end
      @(posedge clk); #1;
      tests++; if ({rsp_valid, rsp_id, rsp_data, rsp_zero} !== {1'b1, 1'b0, 32'd12, 1'b0}) begin fails++; $display("FAIL single_add got v%b id%b %h z%b want v1 id0 0000000c z0", rsp_valid, rsp_id, rsp_data, rsp_zero); end
      @(posedge clk); #1;
      tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL single_drop got %b want 0", rsp_valid); end
      drive(2'b01, 32'd9, 32'd9, 2'b01, 32'd0, 32'd0, 2'b00);
      #1;
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_ready2 got %b want 01", req_ready); end
      @(posedge clk); #1;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      tests++; if ({rsp_valid, rsp_data, rsp_zero, rsp_carry} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin fails++; $display("FAIL single_sub got v%b %h z%b c%b want v1 00000000 z1 c1", rsp_valid, rsp_data, rsp_zero, rsp_carry); end
      @(posedge clk); #1;
   endtask

   task automatic test_contention();
      logic [1:0]  want_rdy;
      logic [31:0] want_d;
      apply_reset();
      rsp_ready = 1'b1;
      drive(2'b11, 32'd1, 32'd2, 2'b00, 32'h8000_0000, 32'd4, 2'b11);
      for (int i = 0; i < 4; i++) begin
         want_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
         want_d   = (i % 2 == 1) ? 32'hF800_0000 : 32'd3;
         #1;
         tests++; if (req_ready !== want_rdy) begin fails++; $display("FAIL contention_grant%0d got %b want %b", i, req_ready, want_rdy); end
         @(posedge clk); @(posedge clk); #1;
         tests++; if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, want_rdy[1], want_d}) begin fails++; $display("FAIL contention_rsp%0d got v%b id%b %h want v1 id%b %h", i, rsp_valid, rsp_id, rsp_data, want_rdy[1], want_d); end
         @(posedge clk);
      end
      #1;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_backpressure();
      apply_reset();
      rsp_ready = 1'b0;
      drive(2'b11, 32'd6, 32'd3, 2'b10, 32'd1, 32'd1, 2'b00);
      #1;
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL bp_grant got %b want 01", req_ready); end
      @(posedge clk); @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         tests++; if ({rsp_valid, rsp_id, rsp_data, req_ready} !== {1'b1, 1'b0, 32'd2, 2'b00}) begin fails++; $display("FAIL bp_hold%0d got v%b id%b %h rdy%b want v1 id0 00000002 rdy00", i, rsp_valid, rsp_id, rsp_data, req_ready); end
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      tests++; if ({rsp_valid, req_ready} !== {1'b0, 2'b10}) begin fails++; $display("FAIL bp_release got v%b rdy%b want v0 rdy10", rsp_valid, req_ready); end
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
   endtask

   task automatic test_reset_midop();
      apply_reset();
      rsp_ready = 1'b1;
      drive(2'b01, 32'd1, 32'd1, 2'b00, 32'd0, 32'd0, 2'b00);
      @(posedge clk); #1;
      reset = 1'b1;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL midop_rsp%0d got %b want 0", i, rsp_valid); end
         @(posedge clk); #1;
      end
      drive(2'b11, 0, 0, 0, 0, 0, 0);
      #1;
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL midop_ptr got %b want 01", req_ready); end
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
   endtask

   task automatic test_idle_pointer();
      apply_reset();
      rsp_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(2'b10, 0, 0, 0, 32'd4, 32'd4, 2'b00);
         #1;
         tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL idle_solo%0d got %b want 10", i, req_ready); end
         @(posedge clk); #1;
         drive(2'b00, 0, 0, 0, 0, 0, 0);
         @(posedge clk); @(posedge clk); #1;
      end
      repeat (3) @(posedge clk);
      #1;
      drive(2'b11, 32'd2, 32'd2, 2'b00, 32'd3, 32'd3, 2'b00);
      #1;
      tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL idle_both got %b want 01", req_ready); end
      @(posedge clk); #1;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      @(posedge clk); @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      drive(2'b11, 32'd2, 32'd2, 2'b00, 32'd3, 32'd3, 2'b00);
      #1;
      tests++; if (req_ready !== 2'b10) begin fails++; $display("FAIL idle_both2 got %b want 10", req_ready); end
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      bit          busy, ptr, exp_v, hs, w;
      int          age;
      logic [1:0]  v, exp_rdy;
      logic        exp_id, exp_z, exp_c;
      logic [31:0] exp_d;
      apply_reset();
      busy = 0; ptr = 0; age = 0;
      exp_id = 0; exp_d = 0; exp_z = 0; exp_c = 0;
      for (int c = 0; c < 400; c++) begin
         exp_v = busy && (age >= 1);
         tests++; if (rsp_valid !== exp_v) begin fails++; $display("FAIL rand_valid c%0d got %b want %b", c, rsp_valid, exp_v); end
         if (exp_v) begin
            tests++;
            if ({rsp_id, rsp_data, rsp_zero, rsp_carry} !== {exp_id, exp_d, exp_z, exp_c}) begin
               fails++;
               $display("FAIL rand_rsp c%0d got id%b %h z%b c%b want id%b %h z%b c%b", c, rsp_id, rsp_data, rsp_zero, rsp_carry, exp_id, exp_d, exp_z, exp_c);
            end
         end
         v = 2'($urandom_range(0, 3));
         drive(v, $urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 2'($urandom_range(0, 3)),
               $urandom, $urandom_range(0, 40), 2'($urandom_range(0, 3)));
         if (req0_funct == 2'b01 && $urandom_range(0, 3) == 0) req0_b = req0_a;
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (busy || v == 2'b00) exp_rdy = 2'b00;
         else if (v == 2'b11)    exp_rdy = ptr ? 2'b10 : 2'b01;
         else                    exp_rdy = v;
         tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rand_ready c%0d got %b want %b", c, req_ready, exp_rdy); end
         hs = exp_v && rsp_ready;
         @(posedge clk); #1;
         if (hs) busy = 0;
         if (exp_rdy != 2'b00) begin
            w = exp_rdy[1];
            busy = 1; age = 0; ptr = ~w; exp_id = w;
            if (w) ref_op(req1_a, req1_b, req1_funct, exp_d, exp_z, exp_c);
            else   ref_op(req0_a, req0_b, req0_funct, exp_d, exp_z, exp_c);
         end else begin
            age++;
         end
      end
      drive(2'b00, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      rsp_ready = 1'b0;
      drive(2'b00, 0, 0, 0, 0, 0, 0);
      test_reset();
      test_single();
      test_contention();
      test_backpressure();
      test_reset_midop();
      test_idle_pointer();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
